// File: rtl/equiv_sweep_ctrl_if.sv
// Bundle of the start/status and function-block signals around the
// equivalence sweep controller. The master side is the controller itself.
interface equiv_sweep_ctrl_if #(
  parameter int N_IN  = 6,
  parameter int N_OUT = 3
);
  logic              start;
  logic              abort;
  logic              stop_on_fail;
  logic [N_IN-1:0]   vec_o;
  logic [N_OUT-1:0]  orig_i;
  logic [N_OUT-1:0]  simp_i;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN-1:0]   fail_vec;
  logic [N_OUT-1:0]  fail_mask;
  logic [N_IN:0]     mismatch_cnt;

  modport master (
    input  start, abort, stop_on_fail, orig_i, simp_i,
    output vec_o, busy, done, pass, fail_vec, fail_mask, mismatch_cnt
  );

  modport slave (
    output start, abort, stop_on_fail, orig_i, simp_i,
    input  vec_o, busy, done, pass, fail_vec, fail_mask, mismatch_cnt
  );
endinterface

// File: rtl/equiv_sweep_ctrl.sv
// Exhaustive equivalence sweep: steps vec_o through every input combination,
// lets the function block settle, then compares original vs simplified outputs.
// Records the first failing vector/pairs and the number of failing vectors.
module equiv_sweep_ctrl #(
  parameter int N_IN       = 6,
  parameter int N_OUT      = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  equiv_sweep_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [3:0]      RELOAD    = 4'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0] VEC_ZERO  = {N_IN{1'b0}};
  localparam logic [N_IN-1:0] VEC_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN-1:0] VEC_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN:0]   CNT_ZERO  = {(N_IN+1){1'b0}};
  localparam logic [N_IN:0]   CNT_ONE   = {{N_IN{1'b0}}, 1'b1};
  localparam logic [N_OUT-1:0] MASK_ZERO = {N_OUT{1'b0}};

  state_t           state_r, state_nxt_s;
  logic [3:0]       settle_r, settle_nxt_s;
  logic             sof_r, sof_nxt_s;
  logic [N_IN-1:0]  vec_r, vec_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             pass_r, pass_nxt_s;
  logic [N_IN-1:0]  fvec_r, fvec_nxt_s;
  logic [N_OUT-1:0] fmask_r, fmask_nxt_s;
  logic [N_IN:0]    mcnt_r, mcnt_nxt_s;

  logic [N_OUT-1:0] diff_s;
  logic             mis_s;
  logic             end_s;

  assign diff_s = bus.orig_i ^ bus.simp_i;
  assign mis_s  = (diff_s != MASK_ZERO);
  // Sweep ends on the last vector, or on the first mismatch when stopping early.
  assign end_s  = (mis_s & sof_r) | (vec_r == VEC_LAST);

  // State register; reset drops any sweep in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; abort outranks the compare transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) state_nxt_s = SETTLE;
        else           state_nxt_s = state_r;
      end
      SETTLE: begin
        if (bus.abort)              state_nxt_s = IDLE;
        else if (settle_r == 4'd0)  state_nxt_s = COMPARE;
        else                        state_nxt_s = SETTLE;
      end
      COMPARE: begin
        if (bus.abort)  state_nxt_s = IDLE;
        else if (end_s) state_nxt_s = DONE;
        else            state_nxt_s = SETTLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Next values of the datapath and status outputs, all registered below.
  always_comb begin
    settle_nxt_s = settle_r;
    sof_nxt_s    = sof_r;
    vec_nxt_s    = vec_r;
    pass_nxt_s   = pass_r;
    fvec_nxt_s   = fvec_r;
    fmask_nxt_s  = fmask_r;
    mcnt_nxt_s   = mcnt_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          fvec_nxt_s   = VEC_ZERO;
          fmask_nxt_s  = MASK_ZERO;
          mcnt_nxt_s   = CNT_ZERO;
          pass_nxt_s   = 1'b0;
          vec_nxt_s    = VEC_ZERO;
          settle_nxt_s = RELOAD;
          sof_nxt_s    = bus.stop_on_fail;
        end else begin
          vec_nxt_s = vec_r;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          vec_nxt_s  = VEC_ZERO;
          pass_nxt_s = 1'b0;
        end else if (settle_r != 4'd0) begin
          settle_nxt_s = settle_r - 4'd1;
        end else begin
          settle_nxt_s = settle_r;
        end
      end
      COMPARE: begin
        if (bus.abort) begin
          vec_nxt_s  = VEC_ZERO;
          pass_nxt_s = 1'b0;
        end else begin
          if (mis_s) begin
            mcnt_nxt_s = mcnt_r + CNT_ONE;
            // Only the first failing vector is recorded.
            if (mcnt_r == CNT_ZERO) begin
              fvec_nxt_s  = vec_r;
              fmask_nxt_s = diff_s;
            end else begin
              fvec_nxt_s  = fvec_r;
            end
          end else begin
            mcnt_nxt_s = mcnt_r;
          end
          if (end_s) begin
            // vec_o stays on the last vector checked.
            pass_nxt_s = ~mis_s & (mcnt_r == CNT_ZERO);
          end else begin
            vec_nxt_s    = vec_r + VEC_ONE;
            settle_nxt_s = RELOAD;
          end
        end
      end
      default: begin
        vec_nxt_s = VEC_ZERO;
      end
    endcase
    busy_nxt_s = (state_nxt_s == SETTLE) || (state_nxt_s == COMPARE);
    done_nxt_s = (state_nxt_s == DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_r <= 4'd0;
      sof_r    <= 1'b0;
      vec_r    <= VEC_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      fvec_r   <= VEC_ZERO;
      fmask_r  <= MASK_ZERO;
      mcnt_r   <= CNT_ZERO;
    end else begin
      settle_r <= settle_nxt_s;
      sof_r    <= sof_nxt_s;
      vec_r    <= vec_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      pass_r   <= pass_nxt_s;
      fvec_r   <= fvec_nxt_s;
      fmask_r  <= fmask_nxt_s;
      mcnt_r   <= mcnt_nxt_s;
    end
  end

  assign bus.vec_o        = vec_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.pass         = pass_r;
  assign bus.fail_vec     = fvec_r;
  assign bus.fail_mask    = fmask_r;
  assign bus.mismatch_cnt = mcnt_r;

endmodule

// File: tb/tb_equiv_sweep_ctrl.sv
// Scoreboard bench for equiv_sweep_ctrl: directed sweeps against a small
// reference function block with selectable injected mismatches.
module tb_equiv_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode = 0;
  int   start_cyc_a = 0;
  int   start_cyc_b = 0;

  typedef struct {
    int pass;
    int cnt;
    int fvec;
    int fmask;
    int last_vec;
    int edges;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  equiv_sweep_ctrl_if #(.N_IN(6), .N_OUT(3)) bus_a ();
  equiv_sweep_ctrl_if #(.N_IN(6), .N_OUT(3)) bus_b ();

  equiv_sweep_ctrl #(.N_IN(6), .N_OUT(3), .SETTLE_CYC(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  equiv_sweep_ctrl #(.N_IN(6), .N_OUT(3), .SETTLE_CYC(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] f_orig(input logic [5:0] v);
    return {v[5] ^ v[0], v[1] & v[2], v[3] | v[4]};
  endfunction

  function automatic logic [2:0] f_err(input logic [5:0] v, input int m);
    if (m == 1 && v == 6'h2A) return 3'b010;
    if (m == 2 && v == 6'h05) return 3'b101;
    if (m == 2 && v == 6'h30) return 3'b001;
    return 3'b000;
  endfunction

  always_comb begin
    bus_a.orig_i = f_orig(bus_a.vec_o);
    bus_a.simp_i = f_orig(bus_a.vec_o) ^ f_err(bus_a.vec_o, mode);
    bus_b.orig_i = f_orig(bus_b.vec_o);
    bus_b.simp_i = f_orig(bus_b.vec_o);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int p, input int c, input int fv,
                              input int fm, input int lv, input int ed);
    exp_t e;
    e.pass = p; e.cnt = c; e.fvec = fv; e.fmask = fm; e.last_vec = lv; e.edges = ed;
    return e;
  endfunction

  // Monitor A: scoreboard compare on done rise, vector stepping, busy/done exclusion.
  logic done_prev_a = 1'b0, busy_prev_a = 1'b0;
  logic [5:0] vec_prev_a = 6'd0;
  int last_chg_a = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus_a.busy && bus_a.done) chk("a_busy_done_excl", 1, 0);
      if (bus_a.done && !done_prev_a) begin
        if (exp_a.size() == 0) begin
          chk("a_unexpected_done", 1, 0);
        end else begin
          e = exp_a.pop_front();
          chk("a_pass", int'(bus_a.pass), e.pass);
          chk("a_mismatch_cnt", int'(bus_a.mismatch_cnt), e.cnt);
          chk("a_fail_vec", int'(bus_a.fail_vec), e.fvec);
          chk("a_fail_mask", int'(bus_a.fail_mask), e.fmask);
          chk("a_last_vec", int'(bus_a.vec_o), e.last_vec);
          chk("a_done_edges", cyc - start_cyc_a, e.edges);
          chk("a_busy_at_done", int'(bus_a.busy), 0);
        end
      end
      if (bus_a.busy && !busy_prev_a) begin
        last_chg_a <= cyc;
      end else if (bus_a.vec_o != vec_prev_a) begin
        if (bus_a.busy && busy_prev_a) begin
          chk("a_vec_step", int'(bus_a.vec_o), int'(vec_prev_a) + 1);
          chk("a_vec_hold", cyc - last_chg_a, 2);
        end
        last_chg_a <= cyc;
      end
    end
    done_prev_a <= bus_a.done;
    busy_prev_a <= bus_a.busy;
    vec_prev_a  <= bus_a.vec_o;
  end

  // Monitor B: SETTLE_CYC=3 instance, four cycles per vector.
  logic done_prev_b = 1'b0, busy_prev_b = 1'b0;
  logic [5:0] vec_prev_b = 6'd0;
  int last_chg_b = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus_b.done && !done_prev_b) begin
        if (exp_b.size() == 0) begin
          chk("b_unexpected_done", 1, 0);
        end else begin
          e = exp_b.pop_front();
          chk("b_pass", int'(bus_b.pass), e.pass);
          chk("b_mismatch_cnt", int'(bus_b.mismatch_cnt), e.cnt);
          chk("b_last_vec", int'(bus_b.vec_o), e.last_vec);
          chk("b_done_edges", cyc - start_cyc_b, e.edges);
        end
      end
      if (bus_b.busy && !busy_prev_b) begin
        last_chg_b <= cyc;
      end else if (bus_b.vec_o != vec_prev_b) begin
        if (bus_b.busy && busy_prev_b) chk("b_vec_hold", cyc - last_chg_b, 4);
        last_chg_b <= cyc;
      end
    end
    done_prev_b <= bus_b.done;
    busy_prev_b <= bus_b.busy;
    vec_prev_b  <= bus_b.vec_o;
  end

  // Start a sweep on A; stop_on_fail is flipped afterwards to exercise its latch.
  task automatic start_a(input int m, input logic sof, input exp_t e, input bit push);
    @(negedge clk);
    mode = m;
    bus_a.stop_on_fail = sof;
    bus_a.start = 1'b1;
    start_cyc_a = cyc + 1;
    if (push) exp_a.push_back(e);
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.stop_on_fail = ~sof;
  endtask

  task automatic wait_done_a(input int bound);
    int n = 0;
    while (!bus_a.done && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus_a.done) chk("a_done_timeout", 0, 1);
  endtask

  task automatic wait_vec_a(input logic [5:0] v, input int bound);
    int n = 0;
    while (bus_a.vec_o != v && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (bus_a.vec_o != v) chk("a_vec_wait_timeout", int'(bus_a.vec_o), int'(v));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"}, int'(bus_a.vec_o), 0);
    chk({tag, "_busy"}, int'(bus_a.busy), 0);
    chk({tag, "_done"}, int'(bus_a.done), 0);
    chk({tag, "_pass"}, int'(bus_a.pass), 0);
    chk({tag, "_fail_vec"}, int'(bus_a.fail_vec), 0);
    chk({tag, "_fail_mask"}, int'(bus_a.fail_mask), 0);
    chk({tag, "_mismatch_cnt"}, int'(bus_a.mismatch_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.stop_on_fail = 1'b0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.stop_on_fail = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    chk("reset_b_busy", int'(bus_b.busy), 0);
    rst_n = 1'b1;

    // Equivalent model, full sweep.
    start_a(0, 1'b0, mk(1, 0, 0, 0, 63, 128), 1'b1);
    wait_done_a(300);
    // abort in DONE changes nothing.
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    chk("done_abort_done", int'(bus_a.done), 1);
    chk("done_abort_vec", int'(bus_a.vec_o), 63);

    // Single mismatch at 0x2A on pair 1.
    start_a(1, 1'b0, mk(0, 1, 8'h2A, 3'b010, 63, 128), 1'b1);
    wait_done_a(300);

    // Mismatches at 0x05 and 0x30, stop at the first.
    start_a(2, 1'b1, mk(0, 1, 8'h05, 3'b101, 5, 12), 1'b1);
    wait_done_a(300);

    // Same model, run to the end.
    start_a(2, 1'b0, mk(0, 2, 8'h05, 3'b101, 63, 128), 1'b1);
    wait_done_a(300);

    // Abort at 0x10 keeps partial results and returns to IDLE.
    start_a(2, 1'b0, mk(0, 0, 0, 0, 0, 0), 1'b0);
    wait_vec_a(6'h10, 100);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    chk("abort_busy", int'(bus_a.busy), 0);
    chk("abort_done", int'(bus_a.done), 0);
    chk("abort_vec", int'(bus_a.vec_o), 0);
    chk("abort_mismatch_cnt", int'(bus_a.mismatch_cnt), 1);
    chk("abort_fail_vec", int'(bus_a.fail_vec), 5);
    chk("abort_fail_mask", int'(bus_a.fail_mask), 5);
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", int'(bus_a.busy), 0);
    start_a(2, 1'b0, mk(0, 2, 8'h05, 3'b101, 63, 128), 1'b1);
    wait_done_a(300);

    // Reset mid-sweep at 0x20 clears everything including partial results.
    start_a(2, 1'b0, mk(0, 0, 0, 0, 0, 0), 1'b0);
    wait_vec_a(6'h20, 100);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rst_n = 1'b1;

    // start pulses while busy are ignored.
    start_a(0, 1'b0, mk(1, 0, 0, 0, 63, 128), 1'b1);
    for (int i = 0; i < 3; i++) begin
      repeat (15) @(negedge clk);
      bus_a.start = 1'b1;
      @(negedge clk);
      bus_a.start = 1'b0;
    end
    wait_done_a(300);

    // SETTLE_CYC=3 instance, equivalent model.
    @(negedge clk);
    bus_b.start = 1'b1;
    start_cyc_b = cyc + 1;
    exp_b.push_back(mk(1, 0, 0, 0, 63, 256));
    @(negedge clk);
    bus_b.start = 1'b0;
    n = 0;
    while (!bus_b.done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!bus_b.done) chk("b_done_timeout", 0, 1);
    @(negedge clk);

    chk("a_queue_drained", exp_a.size(), 0);
    chk("b_queue_drained", exp_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
